// File: rtl/alu_pkg.sv
// alu_pkg: opcode encoding, flag indices and per-opcode flag-update masks
package alu_pkg;
  typedef enum logic [3:0] {
    OP_ADD    = 4'd0,
    OP_SUB    = 4'd1,
    OP_XOR    = 4'd2,
    OP_RED    = 4'd3,
    OP_SLL    = 4'd4,
    OP_SRA    = 4'd5,
    OP_ROR    = 4'd6,
    OP_PADDSB = 4'd7
  } op_e;
  localparam int FLG_Z = 0;
  localparam int FLG_N = 1;
  localparam int FLG_V = 2;
  function automatic logic [2:0] flag_mask(input logic [3:0] op);
    op_e o;
    o = op_e'(op);
    return (o == OP_ADD || o == OP_SUB) ? 3'((1 << FLG_Z) | (1 << FLG_N) | (1 << FLG_V)) :
           (o == OP_XOR || o == OP_SLL || o == OP_SRA || o == OP_ROR) ? 3'(1 << FLG_Z) : 3'b000;
  endfunction
endpackage

// File: rtl/alu_barrel_shift.sv
// alu_barrel_shift: log2-staged SLL/SRA/ROR (mode 0/1/2)
module alu_barrel_shift #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [SHW-1:0]   amt_i,
  input  logic [1:0]       mode_i,
  output logic [WIDTH-1:0] y_o
);
  logic [WIDTH-1:0] stg [SHW+1];
  assign stg[0] = a_i;
  for (genvar s = 0; s < SHW; s++) begin : g_stg
    localparam int K = 1 << s;
    assign stg[s+1] = !amt_i[s] ? stg[s] :
                      mode_i == 2'd0 ? stg[s] << K :
                      mode_i == 2'd1 ? WIDTH'($signed(stg[s]) >>> K) :
                      {stg[s][K-1:0], stg[s][WIDTH-1:K]};
  end
  assign y_o = stg[SHW];
endmodule

// File: rtl/alu_pipe_flags.sv
// alu_pipe_flags: registered saturating ALU with valid/ready output stage and Z/N/V flags
module alu_pipe_flags
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LANE  = 4,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic [SHW-1:0]   imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             out_err,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v
);
  localparam int NB = 2 * WIDTH / 8;
  localparam int NL = WIDTH / LANE;
  op_e              op;
  logic             fire_in, sub, ovf;
  logic [WIDTH-1:0] b_op, sum, add_res, red_res, pad_res, sh_res, calc;
  logic [2*WIDTH-1:0] ab;
  logic [WIDTH-1:0] acc [NB+1];
  logic [2:0]       msk, flg_new, flg_d, flg_q;
  logic             vld_d, vld_q, err_d, err_q;
  logic [WIDTH-1:0] res_d, res_q;
  assign op       = op_e'(opcode);
  assign in_ready = !vld_q || out_ready;
  assign fire_in  = in_valid && in_ready;
  assign sub      = op == OP_SUB;
  assign b_op     = sub ? ~rt : rt;
  assign sum      = rs + b_op + {{(WIDTH-1){1'b0}}, sub};
  assign ovf      = rs[WIDTH-1] == b_op[WIDTH-1] && sum[WIDTH-1] != rs[WIDTH-1];
  assign add_res  = !ovf ? sum : {rs[WIDTH-1], {(WIDTH-1){~rs[WIDTH-1]}}};
  assign ab       = {rt, rs};
  assign acc[0]   = '0;
  for (genvar i = 0; i < NB; i++) begin : g_red
    assign acc[i+1] = acc[i] + {{(WIDTH-8){ab[8*i+7]}}, ab[8*i +: 8]};
  end
  assign red_res = acc[NB];
  for (genvar l = 0; l < NL; l++) begin : g_lane
    logic [LANE-1:0] a, b, s;
    assign a = rs[l*LANE +: LANE];
    assign b = rt[l*LANE +: LANE];
    assign s = a + b;
    assign pad_res[l*LANE +: LANE] = (a[LANE-1] == b[LANE-1] && s[LANE-1] != a[LANE-1]) ?
                                     {a[LANE-1], {(LANE-1){~a[LANE-1]}}} : s;
  end
  alu_barrel_shift #(.WIDTH(WIDTH), .SHW(SHW)) u_shift (
    .a_i   (rs),
    .amt_i (imm),
    .mode_i(opcode[1:0]),
    .y_o   (sh_res)
  );
  // result select and candidate flags for the op being offered
  always_comb begin
    calc = (op == OP_ADD || op == OP_SUB) ? add_res :
           op == OP_XOR ? rs ^ rt :
           op == OP_RED ? red_res :
           (op == OP_SLL || op == OP_SRA || op == OP_ROR) ? sh_res :
           op == OP_PADDSB ? pad_res : '0;
    msk = flag_mask(opcode);
    flg_new = '0;
    flg_new[FLG_Z] = calc == '0;
    flg_new[FLG_N] = calc[WIDTH-1];
    flg_new[FLG_V] = ovf;
  end
  // output stage loads on accept, drains on consume, otherwise holds
  always_comb begin
    vld_d = fire_in || (vld_q && !out_ready);
    res_d = fire_in ? calc : res_q;
    err_d = fire_in ? opcode[3] : err_q;
    flg_d = fire_in ? (msk & flg_new) | (~msk & flg_q) : flg_q;
  end
  // state registers with asynchronous clear
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vld_q <= 1'b0;
      res_q <= '0;
      err_q <= 1'b0;
      flg_q <= '0;
    end else begin
      vld_q <= vld_d;
      res_q <= res_d;
      err_q <= err_d;
      flg_q <= flg_d;
    end
  assign out_valid = vld_q;
  assign result    = res_q;
  assign out_err   = err_q;
  assign flag_z    = flg_q[FLG_Z];
  assign flag_n    = flg_q[FLG_N];
  assign flag_v    = flg_q[FLG_V];
endmodule

// File: tb/tb_alu_pipe_flags.sv
// tb_alu_pipe_flags: directed vectors against hand-computed results and flags
module tb_alu_pipe_flags;
  logic        clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic        in_ready, out_valid, out_err, flag_z, flag_n, flag_v;
  logic [3:0]  opcode = 0;
  logic [15:0] rs = 0, rt = 0, result;
  logic [3:0]  imm = 0;
  int          n_chk = 0, n_pass = 0;
  alu_pipe_flags #(.WIDTH(16), .LANE(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rs(rs), .rt(rt), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .out_err(out_err), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic [3:0] sh);
    opcode = op; rs = a; rt = b; imm = sh; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
  endtask
  task automatic expect_op(input string tag, input logic [15:0] r, input logic [2:0] vnz);
    chk({tag, "_res"}, result, r);
    chk({tag, "_vld"}, out_valid, 1);
    chk({tag, "_vnz"}, {flag_v, flag_n, flag_z}, vnz);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", out_valid, 0);
    chk("rst_res", result, 0);
    chk("rst_flags", {flag_v, flag_n, flag_z}, 0);
    chk("rst_rdy", in_ready, 1);
    rst = 0;
    @(posedge clk); #1;
    issue(4'd0, 16'h7FFF, 16'h0001, 0); expect_op("add_sat", 16'h7FFF, 3'b100);
    chk("add_err", out_err, 0);
    issue(4'd1, 16'h8000, 16'h0001, 0); expect_op("sub_sat", 16'h8000, 3'b110);
    issue(4'd2, 16'h00FF, 16'h00FF, 0); expect_op("xor", 16'h0000, 3'b111);
    issue(4'd7, 16'h7777, 16'h1111, 0); expect_op("padd_pos", 16'h7777, 3'b111);
    issue(4'd7, 16'h8888, 16'h8888, 0); expect_op("padd_neg", 16'h8888, 3'b111);
    issue(4'd7, 16'h1234, 16'h1111, 0); expect_op("padd_ok", 16'h2345, 3'b111);
    issue(4'd3, 16'h0102, 16'h03FF, 0); expect_op("red", 16'h0005, 3'b111);
    issue(4'd5, 16'h8000, 16'h0000, 4); expect_op("sra", 16'hF800, 3'b110);
    issue(4'd6, 16'h0001, 16'h0000, 1); expect_op("ror", 16'h8000, 3'b110);
    issue(4'd6, 16'h1234, 16'h0000, 0); expect_op("ror0", 16'h1234, 3'b110);
    issue(4'd4, 16'h8000, 16'h0000, 1); expect_op("sll", 16'h0000, 3'b111);
    issue(4'd0, 16'h0003, 16'h0004, 0); expect_op("add", 16'h0007, 3'b000);
    @(posedge clk); #1;
    chk("drain_vld", out_valid, 0);
    out_ready = 0;
    issue(4'd0, 16'h0001, 16'h0002, 0); expect_op("bp_add", 16'h0003, 3'b000);
    opcode = 4'd1; rs = 16'h0001; rt = 16'h0005; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_rdy", in_ready, 0);
      @(posedge clk); #1;
      chk("bp_res", result, 16'h0003);
      chk("bp_vld", out_valid, 1);
    end
    out_ready = 1; #1;
    chk("bp_rdy_rel", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0;
    expect_op("bp_sub", 16'hFFFC, 3'b010);
    issue(4'hC, 16'h1234, 16'h5678, 3); expect_op("ill", 16'h0000, 3'b010);
    chk("ill_err", out_err, 1);
    issue(4'd2, 16'h1234, 16'h0000, 0); expect_op("xor2", 16'h1234, 3'b010);
    chk("xor2_err", out_err, 0);
    #2 rst = 1; #1;
    chk("arst_vld", out_valid, 0);
    chk("arst_res", result, 0);
    chk("arst_flags", {flag_v, flag_n, flag_z}, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
